sram_mem_responder: RTL and testbench
=====================================

SRAM_MEM_RESPONDER -- requirements
Module: sram_mem_responder

Interface
REQ-001 Parameter LOG_LINES, default 10, log2 of number of 512-bit storage lines.
REQ-002 Parameter READ_LATENCY, default 2, cycles from read grant to response entering the response queue (range 1..4).
REQ-003 Parameter RESP_LOG_DEPTH, default 2, log2 of response queue entries.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 mem_req_in  input  MemReq  request {valid, isWrite, addr[63:0], data[511:0]}.
REQ-007 mem_req_grant_out  output  1  request accepted this cycle.
REQ-008 mem_resp_out  output  MemResp  read response {valid, data[511:0]}.
REQ-009 mem_resp_grant_in  input  1  consumer takes response this cycle.
REQ-010 busy_out  output  1  high while not in READY state.
REQ-011 rd_count_out  output  32  granted reads since reset.
REQ-012 wr_count_out  output  32  granted writes since reset.
REQ-013 addr_err_out  output  1  sticky out-of-range address flag.

Function
REQ-014 FSM states INIT, READY; reset enters INIT; INIT -> READY per REQ-029/REQ-030; READY is terminal until reset.
REQ-015 Grant is combinational: grant = READY && valid && (isWrite || credit != 0); at most one request accepted per cycle.
REQ-016 Line index = addr[6+LOG_LINES-1:6]; addr[5:0] ignored.
REQ-017 Address out of range when any addr[63:6+LOG_LINES] bit set; on grant of such request addr_err_out sets and stays set until reset.
REQ-018 Granted in-range write stores data at line index; out-of-range write discarded; writes produce no response.
REQ-019 Granted read produces exactly one response; out-of-range read returns all-zero data.
REQ-020 Read granted in cycle N enters response queue at end of cycle N+READ_LATENCY; earliest mem_resp_out.valid in cycle N+READ_LATENCY+1.
REQ-021 Write granted in cycle N is visible to a read granted in cycle N+1 or later.
REQ-022 Credit = 2^RESP_LOG_DEPTH minus (queue occupancy + reads in pipeline); decrements on read grant, increments on response pop; same-cycle grant and pop leave credit unchanged; queue never overflows.
REQ-023 mem_resp_out.valid = queue non-empty; data = queue head; valid and data held stable until mem_resp_grant_in.
REQ-024 Pop when valid && mem_resp_grant_in; grant while valid low ignored.
REQ-025 Responses returned strictly in read-grant order.
REQ-026 rd_count_out/wr_count_out increment on each granted read/write (out-of-range included), wrap 0xFFFFFFFF -> 0.

Reset
REQ-027 On rst_n low: state INIT, grant 0, mem_resp_out.valid 0, data 0, queue and pipeline emptied, credit full, counters 0, addr_err_out 0, busy_out 1.
REQ-028 Reset mid-operation discards in-flight reads with no response; storage contents not cleared by reset itself.

Configuration
REQ-029 Macro SRAM_MEM_RESPONDER_ZERO_INIT_EN defined: INIT sweeps lines 0..2^LOG_LINES-1 writing zero, one line per cycle, then READY; busy_out high and grant low for exactly 2^LOG_LINES cycles after reset release.
REQ-030 Macro undefined: INIT lasts one cycle after reset release; contents unspecified until written (X in simulation).

Verification
REQ-031 Write 0xA5-pattern to addr 0x40, then read 0x40 -> one response, data 0xA5-pattern, valid in cycle grant+3 at default latency.
REQ-032 Write addr 0x80 cycle N, read 0x80 cycle N+1 -> read returns new data.
REQ-033 mem_resp_grant_in held low, 6 back-to-back reads -> exactly 4 granted, grant low thereafter; release grant -> 4 in-order responses, then remaining 2 granted.
REQ-034 Read addr 0x1_0000 (LOG_LINES=10) -> zero data response, addr_err_out 1, rd_count_out 1.
REQ-035 rst_n low with 2 reads in flight -> no responses after release, counters 0, credit 4.
REQ-036 With ZERO_INIT_EN: busy_out high 1024 cycles after reset release; read of line 7 before any write returns 0.

Source files
------------

// File: rtl/sram_mem_responder.sv
// SRAM-backed memory responder: 512-bit lines, fixed-latency reads, credit-guarded response queue.
// Build option: define SRAM_MEM_RESPONDER_ZERO_INIT_EN to zero-sweep all lines while in INIT.
package sram_mem_responder_pkg;
    typedef struct packed {
        logic         valid;
        logic         is_write;
        logic [63:0]  addr;
        logic [511:0] data;
    } mem_req_t;

    typedef struct packed {
        logic         valid;
        logic [511:0] data;
    } mem_resp_t;
endpackage

module sram_mem_responder
    import sram_mem_responder_pkg::*;
#(
    parameter int LOG_LINES      = 10,
    parameter int READ_LATENCY   = 2,
    parameter int RESP_LOG_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  mem_req_t    mem_req_in,
    output logic        mem_req_grant_out,
    output mem_resp_t   mem_resp_out,
    input  logic        mem_resp_grant_in,
    output logic        busy_out,
    output logic [31:0] rd_count_out,
    output logic [31:0] wr_count_out,
    output logic        addr_err_out
);
    localparam int LINES = 1 << LOG_LINES;
    localparam int DEPTH = 1 << RESP_LOG_DEPTH;

    typedef enum logic {INIT, READY} state_t;
    state_t state;

    logic [511:0]                   mem [LINES];
    logic [511:0]                   q_data [DEPTH];
    logic [LOG_LINES-1:0]           idx;
    logic                           oor, grant, rd_fire, wr_fire, push, pop;
    logic [RESP_LOG_DEPTH:0]        credit, q_count;
    logic [RESP_LOG_DEPTH-1:0]      q_wr_ptr, q_rd_ptr;
    logic [READ_LATENCY-1:0]        vld_pipe;
    logic [READ_LATENCY-1:0][511:0] data_pipe;
    logic                           unused_ok;

    assign idx       = mem_req_in.addr[6 +: LOG_LINES];
    assign oor       = |mem_req_in.addr[63:6+LOG_LINES];
    assign unused_ok = ^mem_req_in.addr[5:0];

    // Reads need a credit so the queue can never overflow; writes are always accepted when ready.
    assign grant   = (state == READY) && mem_req_in.valid && (mem_req_in.is_write || credit != '0);
    assign rd_fire = grant && !mem_req_in.is_write;
    assign wr_fire = grant && mem_req_in.is_write;
    assign push    = vld_pipe[READ_LATENCY-1];
    assign pop     = (q_count != '0) && mem_resp_grant_in;

    assign mem_req_grant_out  = grant;
    assign mem_resp_out.valid = (q_count != '0);
    assign mem_resp_out.data  = (q_count != '0) ? q_data[q_rd_ptr] : '0;

`ifdef SRAM_MEM_RESPONDER_ZERO_INIT_EN
    logic [LOG_LINES-1:0] init_idx;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= INIT;
            busy_out <= 1'b1;
`ifdef SRAM_MEM_RESPONDER_ZERO_INIT_EN
            init_idx <= '0;
`endif
        end else if (state == INIT) begin
`ifdef SRAM_MEM_RESPONDER_ZERO_INIT_EN
            init_idx <= init_idx + 1'b1;
            if (&init_idx) begin
                state    <= READY;
                busy_out <= 1'b0;
            end
`else
            state    <= READY;
            busy_out <= 1'b0;
`endif
        end
    end

    // Storage and data path carry no reset so contents survive a reset.
    always_ff @(posedge clk) begin
`ifdef SRAM_MEM_RESPONDER_ZERO_INIT_EN
        if (state == INIT) mem[init_idx] <= '0;
`endif
        if (wr_fire && !oor) mem[idx] <= mem_req_in.data;
        if (rd_fire) data_pipe[0] <= oor ? '0 : mem[idx];
        for (int i = 1; i < READ_LATENCY; i++) data_pipe[i] <= data_pipe[i-1];
        if (push) q_data[q_wr_ptr] <= data_pipe[READ_LATENCY-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe     <= '0;
            q_count      <= '0;
            q_wr_ptr     <= '0;
            q_rd_ptr     <= '0;
            credit       <= (RESP_LOG_DEPTH+1)'(DEPTH);
            rd_count_out <= '0;
            wr_count_out <= '0;
            addr_err_out <= 1'b0;
        end else begin
            vld_pipe[0] <= rd_fire;
            for (int i = 1; i < READ_LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
            if (push) q_wr_ptr <= q_wr_ptr + 1'b1;
            if (pop)  q_rd_ptr <= q_rd_ptr + 1'b1;
            if (push && !pop)      q_count <= q_count + 1'b1;
            else if (!push && pop) q_count <= q_count - 1'b1;
            if (rd_fire && !pop)      credit <= credit - 1'b1;
            else if (!rd_fire && pop) credit <= credit + 1'b1;
            if (rd_fire) rd_count_out <= rd_count_out + 1'b1;
            if (wr_fire) wr_count_out <= wr_count_out + 1'b1;
            if (grant && oor) addr_err_out <= 1'b1;
        end
    end
endmodule

// File: tb/tb_sram_mem_responder.sv
// Directed and randomized bench for sram_mem_responder, checked against a queue-based timing model.
module tb_sram_mem_responder;
    import sram_mem_responder_pkg::*;

    localparam int L     = 2;
    localparam int LINES = 1024;
`ifdef SRAM_MEM_RESPONDER_ZERO_INIT_EN
    localparam int INIT_CYC = LINES;
`else
    localparam int INIT_CYC = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    mem_req_t    req;
    logic        rgrant;
    logic        grant;
    mem_resp_t   resp;
    logic        busy;
    logic [31:0] rdc, wrc;
    logic        aerr;

    sram_mem_responder dut (
        .clk(clk), .rst_n(rst_n),
        .mem_req_in(req), .mem_req_grant_out(grant),
        .mem_resp_out(resp), .mem_resp_grant_in(rgrant),
        .busy_out(busy), .rd_count_out(rdc), .wr_count_out(wrc), .addr_err_out(aerr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [511:0] data;
        int           rdy;
    } exp_t;

    exp_t         q[$];
    logic [511:0] mm [LINES];
    logic [31:0]  m_rd, m_wr;
    logic         m_err, m_ready;
    int           cyc, n_chk, n_pass, n_fail;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic mem_req_t mk(input logic v, input logic w, input logic [63:0] a, input logic [511:0] d);
        mem_req_t r;
        r.valid = v; r.is_write = w; r.addr = a; r.data = d;
        return r;
    endfunction

    function automatic logic [511:0] rnd512();
        logic [511:0] x;
        for (int i = 0; i < 16; i++) x[i*32 +: 32] = $urandom;
        return x;
    endfunction

    // One clock cycle: drive, predict and compare mid-cycle, then advance the model.
    task automatic step(input mem_req_t r, input logic rg, output logic g);
        logic eg, ev, oor;
        int   line;
        exp_t e;
        req = r; rgrant = rg;
        @(negedge clk);
        eg = m_ready && r.valid && (r.is_write || q.size() < 4);
        ev = (q.size() > 0) && (q[0].rdy <= cyc);
        check("grant", grant, eg);
        check("resp_valid", resp.valid, ev);
        if (ev) check("resp_data", resp.data, q[0].data);
        if (eg) begin
            oor  = (r.addr >= 64'h1_0000);
            line = int'((r.addr % 64'h1_0000) / 64);
            if (oor) m_err = 1'b1;
            if (r.is_write) begin
                m_wr++;
                if (!oor) mm[line] = r.data;
            end else begin
                m_rd++;
                e.data = oor ? '0 : mm[line];
                e.rdy  = cyc + L + 1;
                q.push_back(e);
            end
        end
        if (ev && rg) void'(q.pop_front());
        g = eg;
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic drain(input int n);
        logic g;
        for (int i = 0; i < n; i++) step(mk(0, 0, 0, '0), 1'b1, g);
    endtask

    task automatic check_ctrs(input string tag);
        check({tag, "_rd_count"}, rdc, m_rd);
        check({tag, "_wr_count"}, wrc, m_wr);
        check({tag, "_addr_err"}, aerr, m_err);
    endtask

    // Six reads with the consumer stalled: four fit, then release and finish in order.
    task automatic stall_reads(input string tag);
        logic g;
        int   k;
        k = 0;
        for (int c = 0; c < 10; c++) begin
            step(mk(1, 0, 64'(k) * 64, '0), 1'b0, g);
            if (g) k++;
        end
        check({tag, "_stalled_grants"}, k, 4);
        for (int c = 0; c < 40 && (k < 6 || q.size() > 0); c++) begin
            step(k < 6 ? mk(1, 0, 64'(k) * 64, '0) : mk(0, 0, 0, '0), 1'b1, g);
            if (g) k++;
        end
        check({tag, "_all_granted"}, k, 6);
        check({tag, "_queue_drained"}, q.size(), 0);
    endtask

    task automatic do_reset();
        int   n;
        logic g_seen;
        rst_n = 1'b0;
        req = mk(1, 0, 64'h40, '0);
        rgrant = 1'b1;
        q.delete();
        m_rd = '0; m_wr = '0; m_err = 1'b0; m_ready = 1'b0;
`ifdef SRAM_MEM_RESPONDER_ZERO_INIT_EN
        for (int i = 0; i < LINES; i++) mm[i] = '0;
`endif
        @(negedge clk);
        check("rst_grant", grant, 1'b0);
        check("rst_resp_valid", resp.valid, 1'b0);
        check("rst_resp_data", resp.data, '0);
        check("rst_busy", busy, 1'b1);
        check_ctrs("rst");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n = 0;
        g_seen = 1'b0;
        for (int k = 0; k < 4000 && busy; k++) begin
            n++;
            g_seen |= grant;
            @(negedge clk);
        end
        check("init_cycles", n, INIT_CYC);
        check("init_no_grant", g_seen, 1'b0);
        m_ready = 1'b1;
        req = mk(0, 0, 0, '0);
        @(posedge clk);
        cyc++;
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic         g;
        logic [63:0]  a;
        logic [511:0] d;
        req = mk(0, 0, 0, '0);
        rgrant = 1'b0;
        cyc = 0; n_chk = 0; n_pass = 0; n_fail = 0;
        m_rd = '0; m_wr = '0; m_err = 1'b0; m_ready = 1'b0;
        do_reset();

`ifdef SRAM_MEM_RESPONDER_ZERO_INIT_EN
        step(mk(1, 0, 64'(7) * 64, '0), 1'b1, g);
        drain(6);
`endif
        // Out-of-range read as the first read after reset
        step(mk(1, 0, 64'h1_0000, '0), 1'b1, g);
        drain(6);
        check_ctrs("oor_read");

        for (int i = 0; i < 16; i++)
            step(mk(1, 1, 64'(i) * 64 + 64'($urandom_range(0, 63)), rnd512()), 1'b1, g);

        step(mk(1, 1, 64'h40, {64{8'hA5}}), 1'b1, g);
        step(mk(1, 0, 64'h40, '0), 1'b1, g);
        drain(6);

        // Out-of-range write aliasing line 1 must not disturb it
        step(mk(1, 1, 64'h1_0040, rnd512()), 1'b1, g);
        step(mk(1, 0, 64'h40, '0), 1'b1, g);
        drain(6);

        step(mk(1, 1, 64'h80, rnd512()), 1'b1, g);
        step(mk(1, 0, 64'h80, '0), 1'b1, g);
        drain(6);
        check_ctrs("directed");

        stall_reads("stall1");

        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 9) < 1) begin
                a = {$urandom, $urandom};
                a[16] = 1'b1;
            end else begin
                a = 64'($urandom_range(0, 15)) * 64 + 64'($urandom_range(0, 63));
            end
            d = rnd512();
            step(mk($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 4, a, d), $urandom_range(0, 9) < 6, g);
        end
        drain(12);
        check_ctrs("random");
        check("random_queue_drained", q.size(), 0);

        // Reset with two reads in flight
        step(mk(1, 0, 64'h40, '0), 1'b0, g);
        step(mk(1, 0, 64'h80, '0), 1'b0, g);
        do_reset();
        drain(8);
        check_ctrs("post_reset");
        step(mk(1, 0, 64'h40, '0), 1'b1, g);
        step(mk(1, 0, 64'h80, '0), 1'b1, g);
        drain(6);
`ifndef SRAM_MEM_RESPONDER_ZERO_INIT_EN
        for (int i = 0; i < 6; i++) step(mk(1, 1, 64'(i) * 64, rnd512()), 1'b1, g);
`endif
        stall_reads("stall2");
        check_ctrs("final");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
